// File: rtl/sdcmd_pkg.sv
// Shared constants and state encoding for the SD CMD-line serializer.
package sdcmd_pkg;
  localparam int         FRAME_LEN = 48;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    TRAIL = 2'd2
  } state_t;
endpackage

// File: rtl/sdcrc7.sv
// Serial CRC7 (x^7+x^3+1), one message bit per enabled clock; clear wins over enable.
module sdcrc7
  import sdcmd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;
  assign fb = din ^ crc[6];

  always_ff @(posedge clk) begin
    if (clr) begin
      crc <= 7'd0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
    end
  end

endmodule

// File: rtl/sdcmdtx.sv
// SD CMD-line serializer: builds start/dir/index/arg/CRC7/end frame and shifts it out
// one bit per i_ckstb, followed by NIDLE high bits before releasing the line.
module sdcmdtx
  import sdcmd_pkg::*;
#(
  parameter int NIDLE = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ckstb,
  input  logic        i_cmd_valid,
  input  logic [5:0]  i_cmd_index,
  input  logic [31:0] i_cmd_arg,
  output logic        o_busy,
  output logic        o_cmd_en,
  output logic        o_cmd_data,
  output logic        o_done
);

  state_t      state;
  logic [39:0] sreg;      // frame bits 47..8, MSB is the next bit on the wire
  logic [5:0]  bit_cnt;
  logic [3:0]  idle_cnt;
  logic [6:0]  crc;
  logic [2:0]  crc_idx;
  logic        accept;
  logic        crc_step;
  logic        next_bit;

  assign accept   = (state == IDLE) && i_cmd_valid;
  assign crc_step = (state == SEND) && i_ckstb && (bit_cnt < 6'd40);
  assign crc_idx  = 3'(6'd46 - bit_cnt);

  // Frame bits 7..1 come from the CRC, which stops advancing once bit 8 has gone out.
  always_comb begin
    next_bit = 1'b1;
    if (bit_cnt < 6'd40) begin
      next_bit = sreg[39];
    end else if (bit_cnt < 6'd47) begin
      next_bit = crc[crc_idx];
    end
  end

  sdcrc7 u_crc (
    .clk (i_clk),
    .clr (!i_reset_n || accept),
    .en  (crc_step),
    .din (sreg[39]),
    .crc (crc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      sreg       <= 40'd0;
      bit_cnt    <= 6'd0;
      idle_cnt   <= 4'd0;
      o_busy     <= 1'b0;
      o_cmd_en   <= 1'b0;
      o_cmd_data <= 1'b1;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            sreg     <= {2'b01, i_cmd_index, i_cmd_arg};
            bit_cnt  <= 6'd0;
            idle_cnt <= 4'd0;
            o_busy   <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (i_ckstb) begin
            o_cmd_en   <= 1'b1;
            o_cmd_data <= next_bit;
            sreg       <= {sreg[38:0], 1'b0};
            bit_cnt    <= bit_cnt + 6'd1;
            if (bit_cnt == 6'(FRAME_LEN - 1)) begin
              state <= TRAIL;
            end
          end
        end
        TRAIL: begin
          if (i_ckstb) begin
            o_cmd_data <= 1'b1;
            if (idle_cnt == 4'(NIDLE)) begin
              o_cmd_en <= 1'b0;
              o_done   <= 1'b1;
              o_busy   <= 1'b0;
              state    <= IDLE;
            end else begin
              o_cmd_en <= 1'b1;
              idle_cnt <= idle_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdcmdtx.sv
// Scoreboarded bench for sdcmdtx: stimulus pushes expected line states, a monitor checks them.
module tb_sdcmdtx;

  localparam int NIDLE = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ckstb;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy;
  logic        cmd_en;
  logic        cmd_data;
  logic        done;

  int checks   = 0;
  int failures = 0;

  // Each entry is {cmd_en, cmd_data, done} expected in the cycle after a busy strobe.
  logic [2:0] exp_q[$];

  logic ev_d   = 1'b0;
  logic rst_d  = 1'b0;
  logic last_en;
  logic last_data;

  sdcmdtx #(.NIDLE(NIDLE)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_ckstb     (ckstb),
    .i_cmd_valid (cmd_valid),
    .i_cmd_index (cmd_index),
    .i_cmd_arg   (cmd_arg),
    .o_busy      (busy),
    .o_cmd_en    (cmd_en),
    .o_cmd_data  (cmd_data),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a strobe seen while busy must produce exactly the next scoreboard entry.
  always @(posedge clk) begin
    ev_d  <= reset_n && ckstb && busy;
    rst_d <= reset_n;
  end

  always @(negedge clk) begin
    if (ev_d) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 48'({cmd_en, cmd_data, done}), 48'h7);
      end else begin
        check("sb_line", 48'({cmd_en, cmd_data, done}), 48'(exp_q.pop_front()));
      end
    end else if (rst_d) begin
      check("hold_done", 48'(done), 48'd0);
      check("hold_line", 48'({cmd_en, cmd_data}), 48'({last_en, last_data}));
    end
    last_en   = cmd_en;
    last_data = cmd_data;
  end

  task automatic push_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) exp_q.push_back({1'b1, f[i], 1'b0});
    for (int i = 0; i < NIDLE; i++) exp_q.push_back(3'b110);
    exp_q.push_back(3'b011);
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] f);
    push_frame(f);
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_index = 6'h3f;
    cmd_arg   = 32'hffff_ffff;
  endtask

  task automatic strobes(input int n, input int period);
    for (int k = 0; k < n; k++) begin
      ckstb = 1'b1;
      @(negedge clk);
      ckstb = 1'b0;
      repeat (period - 1) @(negedge clk);
    end
  endtask

  // Strobe until o_done is seen; n counts strobes that landed while busy was high.
  task automatic run_until_done(input int period, output int n);
    bit got = 0;
    n = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      ckstb = 1'b1;
      if (busy) n++;
      @(negedge clk);
      if (done) got = 1;
      if (!got && period > 1) begin
        ckstb = 1'b0;
        repeat (period - 1) @(negedge clk);
      end
    end
    ckstb = 1'b0;
    if (!got) check("done_timeout", 48'd0, 48'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    ckstb     = 1'b0;
    cmd_valid = 1'b0;
    cmd_index = 6'd0;
    cmd_arg   = 32'd0;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1;
    ckstb     = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    ckstb     = 1'b0;
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_en",   48'(cmd_en), 48'd0);
    check("rst_data", 48'(cmd_data), 48'd1);
    check("rst_done", 48'(done), 48'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // CMD0, slow strobe
    send_cmd(6'd0, 32'h0000_0000, 48'h40_0000_0000_95);
    run_until_done(4, n);
    check("cmd0_busy_strobes", 48'(n), 48'd51);
    check("cmd0_idle_busy", 48'(busy), 48'd0);

    // CMD8 with check pattern
    repeat (3) @(negedge clk);
    send_cmd(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87);
    run_until_done(3, n);
    check("cmd8_busy_strobes", 48'(n), 48'd51);

    // CMD17, strobe every cycle
    @(negedge clk);
    send_cmd(6'd17, 32'h0000_0000, 48'h51_0000_0000_55);
    run_until_done(1, n);
    check("cmd17_busy_strobes", 48'(n), 48'd51);

    // Clock shutdown mid-argument
    repeat (2) @(negedge clk);
    send_cmd(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87);
    strobes(20, 2);
    repeat (100) @(negedge clk);
    check("stall_busy", 48'(busy), 48'd1);
    run_until_done(2, n);
    check("stall_rest_strobes", 48'(n), 48'd31);

    // Request while busy is ignored; request right after done is accepted
    repeat (2) @(negedge clk);
    send_cmd(6'd0, 32'h0000_0000, 48'h40_0000_0000_95);
    strobes(10, 2);
    cmd_index = 6'd55;
    cmd_arg   = 32'h1234_5678;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    run_until_done(2, n);
    check("ignore_rest_strobes", 48'(n), 48'd41);
    @(negedge clk);
    send_cmd(6'd17, 32'h0000_0000, 48'h51_0000_0000_55);
    check("b2b_busy", 48'(busy), 48'd1);
    run_until_done(2, n);
    check("b2b_busy_strobes", 48'(n), 48'd51);

    // Reset mid-frame, then a fresh CMD0 must carry a clean CRC
    repeat (2) @(negedge clk);
    send_cmd(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87);
    strobes(20, 2);
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_en",   48'(cmd_en), 48'd0);
    check("midrst_data", 48'(cmd_data), 48'd1);
    check("midrst_busy", 48'(busy), 48'd0);
    check("midrst_done", 48'(done), 48'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    send_cmd(6'd0, 32'h0000_0000, 48'h40_0000_0000_95);
    run_until_done(4, n);
    check("postrst_busy_strobes", 48'(n), 48'd51);

    repeat (5) @(negedge clk);
    check("sb_empty", 48'(exp_q.size()), 48'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdcmdtx.md
Name: sdcmdtx

Overview:
- Command-line (CMD pin) serializer that sits directly downstream of the SD clock generator, sdckgen.
- Accepts a command index and 32-bit argument and builds the 48-bit SD command frame: start bit, transmit bit, index, argument, CRC7, end bit.
- Shifts the frame out one bit per clock-generator strobe (`i_ckstb`), then drives a short high idle tail.
- Output feeds the pad front-end (output enable plus data).

Parameters:
- NIDLE, 2, number of trailing '1' bits driven after the end bit before the CMD line is released (1..15).

Ports:
- i_clk  input  1  system clock; the only clock.
- i_reset_n  input  1  synchronous, active-low reset, sampled on rising edge of i_clk.
- i_ckstb  input  1  one-cycle strobe from sdckgen; marks one SD bit period boundary.
- i_cmd_valid  input  1  request to send a command.
- i_cmd_index  input  6  command index (CMD0..CMD63).
- i_cmd_arg  input  32  command argument.
- o_busy  output  1  high while a frame is in flight; requests are ignored while high.
- o_cmd_en  output  1  CMD pad output enable.
- o_cmd_data  output  1  CMD pad data bit.
- o_done  output  1  one-cycle pulse when the line is released.

Behaviour:
- All outputs are registered. Reset (i_reset_n low at a clock edge) applies regardless of state, including mid-frame:
  - o_busy=0, o_cmd_en=0, o_cmd_data=1, o_done=0.
  - State returns to IDLE and the partial frame is discarded; no o_done is issued.
- Frame layout, MSB first (bit 47 sent first):
  - bit 47 = 0 (start)
  - bit 46 = 1 (host transmit)
  - bits 45:40 = index
  - bits 39:8 = arg
  - bits 7:1 = CRC7
  - bit 0 = 1 (end)
- CRC7: polynomial x^7+x^3+1, register initialised to 0, computed over frame bits 47..8.
- States:
  - IDLE: o_busy=0. If i_cmd_valid is high, load the frame and go to SEND; o_busy=1 from the next cycle. i_ckstb in the same cycle is ignored.
  - SEND: on each i_ckstb, register the next frame bit onto o_cmd_data with o_cmd_en=1; the new value is visible the cycle after the strobe. A 6-bit counter tracks bits sent. After the 48th bit's strobe, go to TRAIL.
  - TRAIL: on each of the next NIDLE i_ckstb pulses, o_cmd_data=1 and o_cmd_en=1. On the following i_ckstb: o_cmd_en=0, o_cmd_data=1, o_done=1 for one cycle, o_busy=0, return to IDLE.
- Cycles without i_ckstb hold every output except o_done, which is 0 on those cycles.
- A stalled i_ckstb (clock shutdown) freezes the frame indefinitely; there is no timeout.
- Back-to-back commands: a new i_cmd_valid is accepted on any cycle with o_busy=0, including the cycle after o_done.
- Inputs are sampled only at acceptance; changes while busy have no effect.
- Total line-driven time = 48+NIDLE strobes; release occurs on strobe 49+NIDLE after acceptance.

Decomposition:
- Package sdcmd_pkg:
  - frame length constant 48
  - CRC7 polynomial constant 7'h09
  - state encoding IDLE/SEND/TRAIL (2 bits)
- Sub-module sdcrc7: single-bit serial CRC7 step. Inputs: enable, clear, data bit. Output: 7-bit CRC.
  - Instantiated once; advanced on each i_ckstb in SEND for bits 47..8.
  - Its output is muxed in for bits 7..1.

Test Plan:
- CMD0, arg 0x00000000, i_ckstb every 4 cycles → 48 bits equal 0x40_00000000_95, then 2 ones, then o_cmd_en=0 and a single o_done pulse.
- CMD8, arg 0x000001AA → frame 0x48_000001AA_87; o_busy high for exactly (48+2+1) strobes after acceptance.
- CMD17, arg 0x00000000, i_ckstb every cycle (200 MHz case) → frame 0x51_00000000_55; each bit held exactly 1 cycle.
- Hold i_ckstb low for 100 cycles mid-argument (shutdown) → outputs frozen, no extra bits; resuming strobes continues from the next bit.
- i_cmd_valid asserted with CMD55 while busy → ignored, first frame unaffected. Next valid on the cycle after o_done → accepted, and its start bit 0 appears after the next strobe.
- Assert i_reset_n=0 at bit 20 → next cycle o_cmd_en=0, o_cmd_data=1, o_busy=0, no o_done. A fresh CMD0 afterwards sends the correct 0x..95 frame, proving the CRC register was cleared.
